// File: rtl/cuckoo_chime_ctrl_pkg.sv
// Shared definitions for the cuckoo chime sequencer: FSM states, time limits,
// time-of-day payload and the 12 h hour-advance helper.
package cuckoo_chime_ctrl_pkg;

   localparam int unsigned HOUR_W   = 4;
   localparam int unsigned MIN_W    = 6;
   localparam int unsigned SEC_W    = 6;
   localparam int unsigned CALLS_W  = 4;

   localparam int unsigned HOUR_MAX = 12;
   localparam int unsigned MIN_MAX  = 59;
   localparam int unsigned SEC_MAX  = 59;
   localparam int unsigned HALF_MIN = 30;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALL = 2'd1,
      ST_HOLD = 2'd2,
      ST_GAP  = 2'd3
   } chime_state_e;

   typedef struct packed {
      logic [HOUR_W-1:0] hour;
      logic [MIN_W-1:0]  min;
      logic [SEC_W-1:0]  sec;
   } hms_t;

   // 12 h dial without AM/PM: 12 -> 1, otherwise +1
   function automatic logic [HOUR_W-1:0] next_hour(input logic [HOUR_W-1:0] h);
      return (h == HOUR_W'(HOUR_MAX)) ? HOUR_W'(1) : h + HOUR_W'(1);
   endfunction

endpackage

// File: rtl/cuckoo_chime_ctrl_tick_edge.sv
// Registers the 1 s square wave twice and emits a one-cycle pulse on each
// rising edge. Shared by every block that consumes the 1 s wave.
module cuckoo_chime_ctrl_tick_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic tick_i,
   output logic rise_c
);

   logic tick_q;
   logic tick_q2;

   // two-stage history of the tick wave
   always_ff @(negedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tick_q  <= 1'b0;
         tick_q2 <= 1'b0;
      end else begin
         tick_q  <= tick_i;
         tick_q2 <= tick_q;
      end
   end

   assign rise_c = tick_q & ~tick_q2;

endmodule

// File: rtl/cuckoo_chime_ctrl.sv
// Cuckoo chime sequencer: keeps 12 h time from 1 s ticks and at each top of
// hour runs one bird call per hour (extend bird, request sound, hold, retract).
// Optional feature macro: HALF_HOUR_CHIME_EN adds a single call at hh:30:00.
// All logic runs on the falling edge of sysclk.
module cuckoo_chime_ctrl
   import cuckoo_chime_ctrl_pkg::*;
#(
   parameter int unsigned OUT_TICKS   = 2,
   parameter int unsigned GAP_TICKS   = 1,
   parameter int unsigned ACK_TIMEOUT = 1000000
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic              tick_in,
   input  logic              set_en,
   input  logic [HOUR_W-1:0] set_hour,
   input  logic [MIN_W-1:0]  set_min,
   input  logic              snd_ack,
   output logic [HOUR_W-1:0] hour,
   output logic [MIN_W-1:0]  min,
   output logic [SEC_W-1:0]  sec,
   output logic              bird_out,
   output logic              snd_req,
   output logic              chime_busy
);

   localparam int unsigned TMAX   = (OUT_TICKS > GAP_TICKS) ? OUT_TICKS : GAP_TICKS;
   localparam int unsigned TCNT_W = $clog2(TMAX + 1);
   localparam int unsigned TO_W   = $clog2(ACK_TIMEOUT + 1);

   logic               rise_c;
   logic               set_ok_c;
   logic               trig_c;
   logic [CALLS_W-1:0] trig_calls_c;
   hms_t               time_q;
   hms_t               time_d;
   chime_state_e       state_q;
   logic [TCNT_W-1:0]  tcnt_q;
   logic [TO_W-1:0]    tocnt_q;
   logic [CALLS_W-1:0] calls_left_q;

   cuckoo_chime_ctrl_tick_edge u_tick_edge (
      .clk_i  (sysclk),
      .rst_i  (reset),
      .tick_i (tick_in),
      .rise_c (rise_c)
   );

   // next time-of-day and chime trigger; a valid set wins over a same-cycle tick
   always_comb begin
      time_d       = time_q;
      trig_c       = 1'b0;
      trig_calls_c = '0;
      set_ok_c     = set_en && (set_hour >= HOUR_W'(1)) && (set_hour <= HOUR_W'(HOUR_MAX))
                     && (set_min <= MIN_W'(MIN_MAX));
      if (set_ok_c) begin
         time_d.hour = set_hour;
         time_d.min  = set_min;
         time_d.sec  = '0;
      end else if (rise_c) begin
         if (time_q.sec == SEC_W'(SEC_MAX)) begin
            time_d.sec = '0;
            if (time_q.min == MIN_W'(MIN_MAX)) begin
               time_d.min   = '0;
               time_d.hour  = next_hour(time_q.hour);
               trig_c       = 1'b1;
               trig_calls_c = next_hour(time_q.hour);
            end else begin
               time_d.min = time_q.min + MIN_W'(1);
`ifdef HALF_HOUR_CHIME_EN
               if (time_q.min == MIN_W'(HALF_MIN - 1)) begin
                  trig_c       = 1'b1;
                  trig_calls_c = CALLS_W'(1);
               end
`endif
            end
         end else begin
            time_d.sec = time_q.sec + SEC_W'(1);
         end
      end
   end

   // time-of-day register, resets to 12:00:00
   always_ff @(negedge sysclk or posedge reset) begin
      if (reset) begin
         time_q.hour <= HOUR_W'(HOUR_MAX);
         time_q.min  <= '0;
         time_q.sec  <= '0;
      end else begin
         time_q <= time_d;
      end
   end

   // chime sequencer with registered actuator/sound outputs
   always_ff @(negedge sysclk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         tcnt_q       <= '0;
         tocnt_q      <= '0;
         calls_left_q <= '0;
         bird_out     <= 1'b0;
         snd_req      <= 1'b0;
         chime_busy   <= 1'b0;
      end else if (set_ok_c) begin
         state_q      <= ST_IDLE;
         tcnt_q       <= '0;
         tocnt_q      <= '0;
         calls_left_q <= '0;
         bird_out     <= 1'b0;
         snd_req      <= 1'b0;
         chime_busy   <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (trig_c) begin
                  state_q      <= ST_CALL;
                  calls_left_q <= trig_calls_c;
                  tocnt_q      <= '0;
                  bird_out     <= 1'b1;
                  snd_req      <= 1'b1;
                  chime_busy   <= 1'b1;
               end
            end
            ST_CALL: begin
               if (snd_ack || (tocnt_q == TO_W'(ACK_TIMEOUT - 1))) begin
                  state_q <= ST_HOLD;
                  tcnt_q  <= '0;
                  snd_req <= 1'b0;
               end else begin
                  tocnt_q <= tocnt_q + TO_W'(1);
               end
            end
            ST_HOLD: begin
               if (rise_c) begin
                  if (tcnt_q == TCNT_W'(OUT_TICKS - 1)) begin
                     state_q      <= ST_GAP;
                     tcnt_q       <= '0;
                     calls_left_q <= calls_left_q - CALLS_W'(1);
                     bird_out     <= 1'b0;
                  end else begin
                     tcnt_q <= tcnt_q + TCNT_W'(1);
                  end
               end
            end
            ST_GAP: begin
               if (rise_c) begin
                  if (tcnt_q == TCNT_W'(GAP_TICKS - 1)) begin
                     tcnt_q <= '0;
                     if (calls_left_q != CALLS_W'(0)) begin
                        state_q  <= ST_CALL;
                        tocnt_q  <= '0;
                        bird_out <= 1'b1;
                        snd_req  <= 1'b1;
                     end else begin
                        state_q    <= ST_IDLE;
                        chime_busy <= 1'b0;
                     end
                  end else begin
                     tcnt_q <= tcnt_q + TCNT_W'(1);
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign hour = time_q.hour;
   assign min  = time_q.min;
   assign sec  = time_q.sec;

endmodule

// File: tb/tb_cuckoo_chime_ctrl.sv
// Bench for cuckoo_chime_ctrl: random tick timing, time kept by a
// seconds-of-dial model, chimes checked by counting bird and sound pulses.
module tb_cuckoo_chime_ctrl;

   localparam int ACK_TO  = 20;
   localparam int ACK_DLY = 5;

   logic       sysclk = 1'b0;
   logic       reset;
   logic       tick_in;
   logic       set_en;
   logic [3:0] set_hour;
   logic [5:0] set_min;
   logic       snd_ack;
   logic [3:0] hour;
   logic [5:0] min;
   logic [5:0] sec;
   logic       bird_out;
   logic       snd_req;
   logic       chime_busy;

   int total = 0;
   int bad   = 0;

   // reference model: seconds since 12:00:00 and calls expected from the last trigger
   int mt;
   int exp_calls;

   // pulse monitors
   int bird_pulses, req_pulses, req_len, req_len_min, req_len_max;
   bit bird_prev;
   bit ack_en;
   int ack_wait;

   cuckoo_chime_ctrl #(
      .OUT_TICKS  (2),
      .GAP_TICKS  (1),
      .ACK_TIMEOUT(ACK_TO)
   ) dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .tick_in   (tick_in),
      .set_en    (set_en),
      .set_hour  (set_hour),
      .set_min   (set_min),
      .snd_ack   (snd_ack),
      .hour      (hour),
      .min       (min),
      .sec       (sec),
      .bird_out  (bird_out),
      .snd_req   (snd_req),
      .chime_busy(chime_busy)
   );

   always #5 sysclk = ~sysclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int m_hour(input int t);
      int h;
      h = t / 3600;
      return (h == 0) ? 12 : h;
   endfunction

   function automatic int m_calls(input int t);
      if (t % 3600 == 0) return m_hour(t);
`ifdef HALF_HOUR_CHIME_EN
      if (t % 3600 == 1800) return 1;
`endif
      return 0;
   endfunction

   // one clock: sample outputs at the rising edge, then run the ack responder
   task automatic cyc();
      @(posedge sysclk);
      if (bird_out && !bird_prev) bird_pulses++;
      bird_prev = bird_out;
      if (snd_req) req_len++;
      else if (req_len != 0) begin
         req_pulses++;
         if (req_len < req_len_min) req_len_min = req_len;
         if (req_len > req_len_max) req_len_max = req_len;
         req_len = 0;
      end
      snd_ack = 1'b0;
      if (ack_en && snd_req) begin
         ack_wait++;
         if (ack_wait == ACK_DLY) snd_ack = 1'b1;
      end else begin
         ack_wait = 0;
      end
   endtask

   task automatic clear_counts();
      bird_pulses = 0;
      req_pulses  = 0;
      req_len     = 0;
      req_len_min = 1 << 30;
      req_len_max = 0;
      exp_calls   = 0;
   endtask

   // one second: tick high 2..3 cycles, low 2..4 cycles
   task automatic do_rise();
      int c;
      tick_in = 1'b1;
      repeat ($urandom_range(3, 2)) cyc();
      tick_in = 1'b0;
      repeat ($urandom_range(4, 2)) cyc();
      mt = (mt + 1) % 43200;
      c  = m_calls(mt);
      if (c != 0) exp_calls = c;
   endtask

   task automatic set_time(input int h, input int m);
      set_en   = 1'b1;
      set_hour = 4'(h);
      set_min  = 6'(m);
      cyc();
      set_en = 1'b0;
      cyc();
      if (h >= 1 && h <= 12 && m >= 0 && m <= 59) mt = (h % 12) * 3600 + m * 60;
   endtask

   task automatic drain(output bit timed_out);
      int n;
      n = 0;
      while (chime_busy && n < 200) begin
         do_rise();
         n++;
      end
      repeat (8) cyc();
      timed_out = chime_busy;
   endtask

   task automatic test_reset();
      repeat (3) cyc();
      total++;
      if (hour !== 4'd12 || min !== 6'd0 || sec !== 6'd0 || bird_out !== 1'b0 ||
          snd_req !== 1'b0 || chime_busy !== 1'b0) begin
         bad++;
         $display("FAIL por_state: got %0d:%0d:%0d bird=%b req=%b busy=%b want 12:0:0 0 0 0",
                  hour, min, sec, bird_out, snd_req, chime_busy);
      end
      reset = 1'b0;
      mt = 0;
      cyc();
   endtask

   task automatic test_chime(input int h, input int want_len);
      bit to;
      set_time(h, 59);
      clear_counts();
      for (int i = 0; i < 60; i++) do_rise();
      total++;
      if (hour !== 4'(m_hour(mt)) || min !== 6'd0 || sec !== 6'd0) begin
         bad++;
         $display("FAIL chime_from_%0d_time: got %0d:%0d:%0d want %0d:0:0", h, hour, min, sec, m_hour(mt));
      end
      drain(to);
      total++;
      if (to) begin
         bad++;
         $display("FAIL chime_from_%0d_idle: busy still %b want 0", h, chime_busy);
      end
      total++;
      if (bird_pulses != exp_calls) begin
         bad++;
         $display("FAIL chime_from_%0d_calls: got %0d bird pulses want %0d", h, bird_pulses, exp_calls);
      end
      total++;
      if (req_pulses != exp_calls || req_len_min != want_len || req_len_max != want_len) begin
         bad++;
         $display("FAIL chime_from_%0d_req: got %0d reqs len %0d..%0d want %0d reqs len %0d",
                  h, req_pulses, req_len_min, req_len_max, exp_calls, want_len);
      end
      total++;
      if (hour !== 4'(m_hour(mt)) || min !== 6'((mt / 60) % 60) || sec !== 6'(mt % 60)) begin
         bad++;
         $display("FAIL chime_from_%0d_keeps_time: got %0d:%0d:%0d want %0d:%0d:%0d",
                  h, hour, min, sec, m_hour(mt), (mt / 60) % 60, mt % 60);
      end
   endtask

   task automatic test_timeout();
      ack_en = 1'b0;
      test_chime(1, ACK_TO);
      ack_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      int n;
      set_time(4, 59);
      for (int i = 0; i < 60; i++) do_rise();
      n = 0;
      while (!bird_out && n < 20) begin cyc(); n++; end
      @(posedge sysclk);
      reset = 1'b1;
      #1;
      total++;
      if (hour !== 4'd12 || min !== 6'd0 || sec !== 6'd0 || bird_out !== 1'b0 ||
          snd_req !== 1'b0 || chime_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: got %0d:%0d:%0d bird=%b req=%b busy=%b want 12:0:0 0 0 0",
                  hour, min, sec, bird_out, snd_req, chime_busy);
      end
      repeat (3) cyc();
      reset = 1'b0;
      mt = 0;
      clear_counts();
      for (int i = 0; i < 5; i++) do_rise();
      total++;
      if (bird_pulses != 0 || req_pulses != 0 || req_len != 0 || chime_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_residue: got bird=%0d req=%0d busy=%b want 0 0 0", bird_pulses, req_pulses, chime_busy);
      end
      total++;
      if (hour !== 4'd12 || min !== 6'd0 || sec !== 6'd5) begin
         bad++;
         $display("FAIL reset_restart_time: got %0d:%0d:%0d want 12:0:5", hour, min, sec);
      end
   endtask

   task automatic test_set_abort();
      int n;
      set_time(3, 59);
      clear_counts();
      for (int i = 0; i < 60; i++) do_rise();
      n = 0;
      while (bird_pulses < 2 && n < 40) begin do_rise(); n++; end
      total++;
      if (bird_out !== 1'b1 || chime_busy !== 1'b1) begin
         bad++;
         $display("FAIL abort_precond: got bird=%b busy=%b want 1 1", bird_out, chime_busy);
      end
      set_en = 1'b1; set_hour = 4'd7; set_min = 6'd15;
      cyc();
      set_en = 1'b0;
      mt = 7 * 3600 + 15 * 60;
      total++;
      if (bird_out !== 1'b0 || snd_req !== 1'b0 || chime_busy !== 1'b0 ||
          hour !== 4'd7 || min !== 6'd15 || sec !== 6'd0) begin
         bad++;
         $display("FAIL abort_set: got %0d:%0d:%0d bird=%b req=%b busy=%b want 7:15:0 0 0 0",
                  hour, min, sec, bird_out, snd_req, chime_busy);
      end
      set_time(13, 20);
      set_time(5, 60);
      set_time(0, 10);
      total++;
      if (hour !== 4'd7 || min !== 6'd15 || sec !== 6'd0) begin
         bad++;
         $display("FAIL bad_set_ignored: got %0d:%0d:%0d want 7:15:0", hour, min, sec);
      end
      clear_counts();
      set_time(5, 0);
      for (int i = 0; i < 4; i++) do_rise();
      total++;
      if (bird_pulses != 0 || hour !== 4'd5 || min !== 6'd0 || sec !== 6'd4) begin
         bad++;
         $display("FAIL set_00_no_chime: got %0d pulses %0d:%0d:%0d want 0 pulses 5:0:4", bird_pulses, hour, min, sec);
      end
   endtask

   task automatic test_set_vs_tick();
      tick_in = 1'b1;
      cyc();
      set_en = 1'b1; set_hour = 4'd8; set_min = 6'd40;
      cyc();
      set_en = 1'b0;
      repeat (2) cyc();
      tick_in = 1'b0;
      repeat (3) cyc();
      mt = 8 * 3600 + 40 * 60;
      total++;
      if (hour !== 4'd8 || min !== 6'd40 || sec !== 6'd0) begin
         bad++;
         $display("FAIL set_beats_tick: got %0d:%0d:%0d want 8:40:0", hour, min, sec);
      end
   endtask

   task automatic test_half_hour();
      bit to;
      set_time(4, 29);
      for (int i = 0; i < 59; i++) do_rise();
      clear_counts();
      total++;
      if (hour !== 4'd4 || min !== 6'd29 || sec !== 6'd59) begin
         bad++;
         $display("FAIL half_precond: got %0d:%0d:%0d want 4:29:59", hour, min, sec);
      end
      do_rise();
      drain(to);
      total++;
      if (to || bird_pulses != exp_calls || req_pulses != exp_calls) begin
         bad++;
         $display("FAIL half_hour: got %0d pulses %0d reqs busy=%b want %0d", bird_pulses, req_pulses, to, exp_calls);
      end
   endtask

   task automatic test_random();
      int h, m, n;
      bit to;
      for (int k = 0; k < 6; k++) begin
         h = int'($urandom_range(15, 0));
         m = int'($urandom_range(63, 0));
         set_time(h, m);
         n = int'($urandom_range(20, 1));
         for (int i = 0; i < n; i++) begin
            do_rise();
            total++;
            if (hour !== 4'(m_hour(mt)) || min !== 6'((mt / 60) % 60) || sec !== 6'(mt % 60)) begin
               bad++;
               $display("FAIL random_time: got %0d:%0d:%0d want %0d:%0d:%0d",
                        hour, min, sec, m_hour(mt), (mt / 60) % 60, mt % 60);
            end
         end
         drain(to);
      end
   endtask

   initial begin
      reset    = 1'b1;
      tick_in  = 1'b0;
      set_en   = 1'b0;
      set_hour = 4'd0;
      set_min  = 6'd0;
      snd_ack  = 1'b0;
      ack_en   = 1'b1;
      ack_wait = 0;
      bird_prev = 1'b0;
      mt = 0;
      clear_counts();

      test_reset();
      test_chime(2, ACK_DLY);
      test_chime(11, ACK_DLY);
      test_chime(12, ACK_DLY);
      test_timeout();
      test_set_abort();
      test_set_vs_tick();
      test_half_hour();
      test_reset_mid();
      test_random();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
